// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed display scan controller: slot counter, blanking,
// PWM brightness, frame-synchronous double buffering and leading-zero blanking.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_STEP     = 60,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  brightness,
  input  logic        lz_en,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [1:0]  mux,
  output logic        disp_en,
  output logic        frame_done
);

  localparam int EW = CNT_W + 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mux_q, mux_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [3:0]       bri_q, bri_d;
  logic             disp_en_q, disp_en_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             boundary;
  logic             suppressed;
  logic [EW-1:0]    cnt_ext;
  logic [EW-1:0]    on_end;

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
    cnt_d        = cnt_q;
    mux_d        = mux_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    bri_d        = bri_q;
    frame_done_d = 1'b0;
    suppressed   = 1'b0;

    slot_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    boundary = enable && slot_end && (mux_q == 2'd3);

    if (!enable) begin
      cnt_d = '0;
      mux_d = 2'd0;
    end else if (slot_end) begin
      cnt_d = '0;
      mux_d = mux_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // A load coinciding with the boundary is newer than anything pending, so it bypasses.
    if (boundary) begin
      frame_done_d = 1'b1;
      if (load) begin
        active_d  = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (cnt_d == '0) bri_d = brightness;

    if (lz_en) begin
      case (mux_d)
        2'd1:    suppressed = (active_d[15:4]  == 12'h000);
        2'd2:    suppressed = (active_d[15:8]  == 8'h00);
        2'd3:    suppressed = (active_d[15:12] == 4'h0);
        default: suppressed = 1'b0;
      endcase
    end

    // Computed from next-cycle values so the registered enable lines up with cnt/mux.
    cnt_ext   = EW'(cnt_d);
    on_end    = EW'(BLANK_CYCLES) + EW'(bri_d) * EW'(PWM_STEP);
    disp_en_d = enable && (cnt_ext >= EW'(BLANK_CYCLES)) && (cnt_ext < on_end) && !suppressed;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      cnt_q        <= '0;
      mux_q        <= 2'd0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      bri_q        <= '0;
      disp_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mux_q        <= mux_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      bri_q        <= bri_d;
      disp_en_q    <= disp_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit1     = active_q[3:0];
  assign digit2     = active_q[7:4];
  assign digit3     = active_q[11:8];
  assign digit4     = active_q[15:12];
  assign mux        = mux_q;
  assign disp_en    = disp_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: cycle-level scan expectations plus a
// scoreboard of loaded values that must appear on digit1..4 at frame boundaries.
module tb_display_scan_ctrl;

  localparam int CD    = 40;
  localparam int BLANK = 4;
  localparam int STEP  = 2;
  localparam int FRAME = 4 * CD;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, lz_en;
  logic [15:0] value;
  logic [3:0]  brightness;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic [1:0]  mux;
  logic        disp_en, frame_done;

  int          total = 0;
  int          bad   = 0;
  int          k     = 0;
  logic [3:0]  bri_s = 4'd0;
  logic [15:0] shown = 16'h0000;
  logic [15:0] sb[$];

  display_scan_ctrl #(
    .CLK_DIV(CD), .BLANK_CYCLES(BLANK), .PWM_STEP(STEP), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .brightness(brightness), .lz_en(lz_en),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .mux(mux), .disp_en(disp_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One clock: advance the expected scan position, then compare every output.
  task automatic step();
    logic       en_e, rst_e, lz_e, fd_e, de_e, supp;
    logic [3:0] br_e;
    int         cnt_e, mux_e;
    en_e = enable; rst_e = rst_n; lz_e = lz_en; br_e = brightness;
    @(posedge clk); #1;
    if (!rst_e) begin
      k = 0; bri_s = 4'd0; shown = 16'h0000; sb.delete();
    end else begin
      k = en_e ? k + 1 : 0;
      if (k % CD == 0) bri_s = br_e;
      if (frame_done === 1'b1 && sb.size() > 0) begin
        shown = sb[$];
        sb.delete();
      end
    end
    cnt_e = k % CD;
    mux_e = (k / CD) % 4;
    fd_e  = rst_e && en_e && k > 0 && (k % FRAME == 0);
    supp  = lz_e && mux_e > 0 && ((shown >> (4 * mux_e)) == 16'h0000);
    de_e  = rst_e && en_e && cnt_e >= BLANK && cnt_e < BLANK + bri_s * STEP && !supp;
    check("mux", 32'(mux), 32'(mux_e));
    check("disp_en", 32'(disp_en), 32'(de_e));
    check("frame_done", 32'(frame_done), 32'(fd_e));
    check("digits", 32'({digit4, digit3, digit2, digit1}), 32'(shown));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    sb.push_back(v);
    step();
    load  = 1'b0;
  endtask

  // Advance until the current cycle sits at frame phase p (cnt + 40*mux).
  task automatic run_to(input int p);
    int n = 0;
    while ((k % FRAME) != p && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("run_to_reached", 32'(k % FRAME), 32'(p));
  endtask

  // Halt for one edge (samples brightness), then scan again from slot 0.
  task automatic restart(input logic [3:0] b);
    enable     = 1'b0;
    brightness = b;
    step();
    enable     = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; lz_en = 1'b0;
    value = 16'h0000; brightness = 4'd0;

    // T1 reset / idle
    run(5);
    rst_n = 1'b1;
    run(5);

    // T2 full-brightness scan over two frames
    restart(4'd15);
    run(2 * FRAME + 10);

    // T3 tear-free update: load at slot 1, cnt 10
    run_to(CD + 10);
    do_load(16'h1234);
    run(FRAME);

    // T4 last load wins; load on the boundary cycle bypasses
    run_to(60);
    do_load(16'h9999);
    run_to(100);
    do_load(16'h0042);
    run_to(10);
    run_to(FRAME - 1);
    do_load(16'h5678);
    run(20);

    // T5 PWM and leading-zero suppression
    restart(4'd0);
    run(FRAME + 10);
    restart(4'd3);
    run(FRAME + 10);
    restart(4'd15);
    lz_en = 1'b1;
    do_load(16'h0007);
    run(2 * FRAME);
    do_load(16'h0050);
    run(2 * FRAME);
    do_load(16'h0000);
    run(2 * FRAME);
    lz_en = 1'b0;

    // T6 disable mid slot 2, then reset with a pending load
    do_load(16'h8888);
    run_to(2 * CD + 10);
    enable = 1'b0;
    step();
    enable = 1'b1;
    run(60);
    enable = 1'b0;
    do_load(16'h5555);
    enable = 1'b1;
    run(FRAME + 10);
    run_to(50);
    do_load(16'h4321);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
